// File: rtl/ascal_win_pkg.sv
// Shared types and constants for the ascal output-window sequencer.
package ascal_win_pkg;

  localparam int unsigned W_DEF = 12;

  typedef enum logic [1:0] {
    M_1TO1,
    M_INT,
    M_FIT,
    M_STRETCH
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISCALE,
    DIV1,
    CHK,
    DIV2,
    CENTER,
    COMMIT
  } state_t;

  // PS/2 set-2 make codes for the function keys used as mode hotkeys.
  localparam logic [7:0] KEY_F1 = 8'h05;
  localparam logic [7:0] KEY_F2 = 8'h06;
  localparam logic [7:0] KEY_F3 = 8'h04;
  localparam logic [7:0] KEY_F4 = 8'h0C;
  localparam logic [7:0] KEY_F5 = 8'h03;

endpackage

// File: rtl/ascal_win_if.sv
// Control/result bundle between the pattern/control logic and the window sequencer.
interface ascal_win_if #(
  parameter int unsigned W = 12
);
  logic         req;
  logic [1:0]   mode;
  logic [W-1:0] hdisp;
  logic [W-1:0] vdisp;
  logic [W-1:0] in_w;
  logic [W-1:0] in_h;
  logic [10:0]  ps2_key;
  logic [W-1:0] hmin;
  logic [W-1:0] hmax;
  logic [W-1:0] vmin;
  logic [W-1:0] vmax;
  logic         upd;
  logic         busy;
  logic         err;

  modport master (
    output req, mode, hdisp, vdisp, in_w, in_h, ps2_key,
    input  hmin, hmax, vmin, vmax, upd, busy, err
  );

  modport slave (
    input  req, mode, hdisp, vdisp, in_w, in_h, ps2_key,
    output hmin, hmax, vmin, vmax, upd, busy, err
  );
endinterface

// File: rtl/ascal_win_div.sv
// Sequential restoring divider: 2W-bit numerator / W-bit nonzero denominator, one bit per cycle.
// done is high in the cycle the last quotient bit is produced; quo is valid the cycle after.
module ascal_win_div #(
  parameter int unsigned W = 12
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [2*W-1:0] num,
  input  logic [W-1:0]   den,
  output logic           done,
  output logic [2*W-1:0] quo
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = $clog2(W2 + 1);

  logic [W2-1:0] quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  den_q;
  logic [CW-1:0] cnt_q;

  logic [W:0]    rem_sh;
  logic [W:0]    rem_sub;
  logic          ge;

  // Shift the next numerator bit into the partial remainder; it always fits back in W bits.
  assign rem_sh  = {rem_q, quo_q[W2-1]};
  assign rem_sub = rem_sh - {1'b0, den_q};
  assign ge      = (rem_sh >= {1'b0, den_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= num;
      rem_q <= '0;
      den_q <= den;
      cnt_q <= CW'(W2);
    end else if (cnt_q != '0) begin
      quo_q <= {quo_q[W2-2:0], ge};
      rem_q <= ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done = (cnt_q == CW'(1));
  assign quo  = quo_q;

endmodule

// File: rtl/ascal_win_ctrl.sv
// Scaler output-window sequencer: derives hmin/hmax/vmin/vmax from display and source size.
// Optional keyboard mode override is built when ASCAL_WIN_KEYB_EN is defined.
module ascal_win_ctrl
  import ascal_win_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter bit          AUTO_REQ = 1'b1
) (
  input logic       clk,
  input logic       reset_n,
  ascal_win_if.slave win
);

  localparam int unsigned W2 = 2 * W;

  function automatic logic [W-1:0] sat_q(input logic [W2-1:0] q);
    return (|q[W2-1:W]) ? '1 : q[W-1:0];
  endfunction

  function automatic logic [W-1:0] umin(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t       state_q;
  logic [1:0]   mode_eff;
  logic [1:0]   mode_q;
  logic [W-1:0] hdisp_q, vdisp_q, in_w_q, in_h_q;
  logic         pending_q, err_next_q, w_div_q;
  logic [W-1:0] aw_q, ah_q, w_q, h_q;
  logic [W-1:0] hmin_q, hmax_q, vmin_q, vmax_q;
  logic         upd_q, err_q;

`ifdef ASCAL_WIN_KEYB_EN
  logic       key_tog_q;
  logic       ovr_act_q;
  logic [1:0] ovr_mode_q;

  // A new PS/2 event is signalled by bit10 toggling; only non-extended make codes count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_tog_q  <= 1'b0;
      ovr_act_q  <= 1'b0;
      ovr_mode_q <= 2'd0;
    end else begin
      key_tog_q <= win.ps2_key[10];
      if ((win.ps2_key[10] != key_tog_q) && win.ps2_key[9] && !win.ps2_key[8]) begin
        case (win.ps2_key[7:0])
          KEY_F1:  begin ovr_act_q <= 1'b1; ovr_mode_q <= 2'd0; end
          KEY_F2:  begin ovr_act_q <= 1'b1; ovr_mode_q <= 2'd1; end
          KEY_F3:  begin ovr_act_q <= 1'b1; ovr_mode_q <= 2'd2; end
          KEY_F4:  begin ovr_act_q <= 1'b1; ovr_mode_q <= 2'd3; end
          KEY_F5:  ovr_act_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign mode_eff = ovr_act_q ? ovr_mode_q : win.mode;
`else
  logic unused_ps2;
  assign unused_ps2 = ^win.ps2_key;
  assign mode_eff   = win.mode;
`endif

  logic  diff, start_idle, start_busy, in_zero;
  mode_t lmode;

  assign diff = (mode_eff != mode_q) || (win.hdisp != hdisp_q) || (win.vdisp != vdisp_q) ||
                (win.in_w != in_w_q) || (win.in_h != in_h_q);
  assign start_idle = win.req || (AUTO_REQ && diff);
  // In LATCH the inputs are being captured, so a mismatch there is not a new request.
  assign start_busy = win.req || (AUTO_REQ && diff && (state_q != LATCH));
  assign in_zero    = (win.in_w == '0) || (win.in_h == '0);
  assign lmode      = in_zero ? M_STRETCH : mode_t'(mode_eff);

  logic [W:0] sum_w, sum_h;
  logic       grow;

  assign sum_w = {1'b0, aw_q} + {1'b0, in_w_q};
  assign sum_h = {1'b0, ah_q} + {1'b0, in_h_q};
  assign grow  = (sum_w <= {1'b0, hdisp_q}) && (sum_h <= {1'b0, vdisp_q});

  logic          div_start, div_done;
  logic [W2-1:0] div_num, div_quo;
  logic [W-1:0]  div_den, div_sat;
  logic          h_fits;

  assign div_sat = sat_q(div_quo);
  assign h_fits  = (div_sat <= vdisp_q);

  always_comb begin
    div_start = 1'b0;
    div_num   = '0;
    div_den   = '0;
    if ((state_q == LATCH) && (lmode == M_FIT)) begin
      div_start = 1'b1;
      div_num   = W2'(win.hdisp) * W2'(win.in_h);
      div_den   = win.in_w;
    end else if ((state_q == CHK) && !h_fits) begin
      div_start = 1'b1;
      div_num   = W2'(vdisp_q) * W2'(in_w_q);
      div_den   = in_h_q;
    end
  end

  ascal_win_div #(
    .W(W)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (div_start),
    .num    (div_num),
    .den    (div_den),
    .done   (div_done),
    .quo    (div_quo)
  );

  logic [W-1:0] w_c, hmin_c, hmax_c, vmin_c, vmax_c;

  // After DIV2 the width comes straight from the divider; hmax wraps to all-ones when w is 0.
  assign w_c    = w_div_q ? div_sat : w_q;
  assign hmin_c = (hdisp_q - w_c) >> 1;
  assign hmax_c = hmin_c + w_c - W'(1);
  assign vmin_c = (vdisp_q - h_q) >> 1;
  assign vmax_c = vmin_c + h_q - W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      hdisp_q    <= '0;
      vdisp_q    <= '0;
      in_w_q     <= '0;
      in_h_q     <= '0;
      pending_q  <= 1'b0;
      err_next_q <= 1'b0;
      w_div_q    <= 1'b0;
      aw_q       <= '0;
      ah_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      hmin_q     <= '0;
      hmax_q     <= '0;
      vmin_q     <= '0;
      vmax_q     <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if ((state_q != IDLE) && (state_q != COMMIT) && start_busy) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (start_idle) state_q <= LATCH;
        end
        LATCH: begin
          mode_q     <= mode_eff;
          hdisp_q    <= win.hdisp;
          vdisp_q    <= win.vdisp;
          in_w_q     <= win.in_w;
          in_h_q     <= win.in_h;
          err_next_q <= in_zero;
          w_div_q    <= 1'b0;
          case (lmode)
            M_STRETCH: begin
              w_q     <= win.hdisp;
              h_q     <= win.vdisp;
              state_q <= CENTER;
            end
            M_1TO1: begin
              w_q     <= umin(win.in_w, win.hdisp);
              h_q     <= umin(win.in_h, win.vdisp);
              state_q <= CENTER;
            end
            M_INT: begin
              aw_q    <= win.in_w;
              ah_q    <= win.in_h;
              state_q <= ISCALE;
            end
            default: state_q <= DIV1;
          endcase
        end
        ISCALE: begin
          if (grow) begin
            aw_q <= sum_w[W-1:0];
            ah_q <= sum_h[W-1:0];
          end else begin
            w_q     <= umin(aw_q, hdisp_q);
            h_q     <= umin(ah_q, vdisp_q);
            state_q <= CENTER;
          end
        end
        DIV1: begin
          if (div_done) state_q <= CHK;
        end
        CHK: begin
          if (h_fits) begin
            w_q     <= hdisp_q;
            h_q     <= div_sat;
            state_q <= CENTER;
          end else begin
            h_q     <= vdisp_q;
            w_div_q <= 1'b1;
            state_q <= DIV2;
          end
        end
        DIV2: begin
          if (div_done) state_q <= CENTER;
        end
        CENTER: begin
          hmin_q  <= hmin_c;
          hmax_q  <= hmax_c;
          vmin_q  <= vmin_c;
          vmax_q  <= vmax_c;
          err_q   <= err_next_q;
          upd_q   <= 1'b1;
          state_q <= COMMIT;
        end
        COMMIT: begin
          if (pending_q || start_busy) begin
            pending_q <= 1'b0;
            state_q   <= LATCH;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win.hmin = hmin_q;
  assign win.hmax = hmax_q;
  assign win.vmin = vmin_q;
  assign win.vmax = vmax_q;
  assign win.upd  = upd_q;
  assign win.err  = err_q;
  assign win.busy = (state_q != IDLE);

endmodule

// File: tb/tb_ascal_win_ctrl.sv
// Directed bench for ascal_win_ctrl: expected windows are queued at stimulus time and
// checked against each upd pulse, including latency, busy coverage and reset abort.
module tb_ascal_win_ctrl;

  logic clk;
  logic reset_n;
  int   cyc;
  int   tests;
  int   fails;

  ascal_win_if #(.W(12)) win ();

  ascal_win_ctrl dut (
    .clk    (clk),
    .reset_n(reset_n),
    .win    (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string tag;
    int    hmin, hmax, vmin, vmax, err, lat;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input string tag, input int a, input int b, input int c,
                              input int d, input int e, input int lat);
    exp_t x;
    x.tag = tag; x.hmin = a; x.hmax = b; x.vmin = c; x.vmax = d; x.err = e; x.lat = lat;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input int m, input int hd, input int vd, input int iw,
                       input int ih, input exp_t e, input bit push, output int t0);
    @(negedge clk);
    win.mode  = 2'(m);
    win.hdisp = 12'(hd);
    win.vdisp = 12'(vd);
    win.in_w  = 12'(iw);
    win.in_h  = 12'(ih);
    win.req   = 1'b1;
    t0 = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    win.req = 1'b0;
  endtask

  task automatic wait_upd(input int t0, input int bound);
    exp_t e;
    int   gaps;
    bit   got;
    gaps = 0;
    got  = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (win.upd === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (win.busy !== 1'b1) gaps++;
      @(negedge clk);
    end
    check("upd_seen", 32'(got), 32'd1);
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".hmin"}, 32'(win.hmin), e.hmin);
      check({e.tag, ".hmax"}, 32'(win.hmax), e.hmax);
      check({e.tag, ".vmin"}, 32'(win.vmin), e.vmin);
      check({e.tag, ".vmax"}, 32'(win.vmax), e.vmax);
      check({e.tag, ".err"}, 32'(win.err), e.err);
      check({e.tag, ".busy_gap"}, gaps, 0);
      if (e.lat >= 0) check({e.tag, ".latency"}, cyc - t0, e.lat);
    end
    @(negedge clk);
    check("upd_pulse", 32'(win.upd), 32'd0);
  endtask

  int t0;

  initial begin
    tests = 0;
    fails = 0;
    win.req = 1'b0;
    win.mode = 2'd0;
    win.hdisp = '0;
    win.vdisp = '0;
    win.in_w = '0;
    win.in_h = '0;
    win.ps2_key = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.hmin", 32'(win.hmin), 0);
    check("rst.hmax", 32'(win.hmax), 0);
    check("rst.vmin", 32'(win.vmin), 0);
    check("rst.vmax", 32'(win.vmax), 0);
    check("rst.upd", 32'(win.upd), 0);
    check("rst.busy", 32'(win.busy), 0);
    check("rst.err", 32'(win.err), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(win.busy), 0);

    apply("m3", 3, 1920, 1080, 320, 240, mk("m3", 0, 1919, 0, 1079, 0, 3), 1'b1, t0);
    wait_upd(t0, 20);
    check("idle_after_m3", 32'(win.busy), 0);

    apply("m0", 0, 1920, 1080, 320, 240, mk("m0", 800, 1119, 420, 659, 0, 3), 1'b1, t0);
    wait_upd(t0, 20);

    apply("m1", 1, 1920, 1080, 320, 240, mk("m1", 320, 1599, 60, 1019, 0, 7), 1'b1, t0);
    wait_upd(t0, 30);

    apply("m2", 2, 1920, 1080, 320, 240, mk("m2", 240, 1679, 0, 1079, 0, 52), 1'b1, t0);
    wait_upd(t0, 100);

    apply("err", 2, 1920, 1080, 0, 240, mk("err", 0, 1919, 0, 1079, 1, 3), 1'b1, t0);
    wait_upd(t0, 20);
    apply("err_clr", 0, 1920, 1080, 320, 240, mk("err_clr", 800, 1119, 420, 659, 0, 3), 1'b1,
          t0);
    wait_upd(t0, 20);

    // Input change while busy: a second window follows the first.
    apply("m2_a", 2, 1920, 1080, 320, 240, mk("m2_a", 240, 1679, 0, 1079, 0, 52), 1'b1, t0);
    repeat (5) @(negedge clk);
    win.in_w = 12'd640;
    sb.push_back(mk("m2_pend", 0, 1919, 180, 899, 0, -1));
    wait_upd(t0, 100);
    wait_upd(t0, 100);

    // Reset mid-compute: abort, outputs cleared, then auto-start from the zeroed latches.
    apply("m2_abort", 2, 1920, 1080, 320, 240, mk("unused", 0, 0, 0, 0, 0, 0), 1'b0, t0);
    repeat (10) @(negedge clk);
    win.in_w = 12'd640;
    reset_n  = 1'b0;
    @(negedge clk);
    check("abort.hmin", 32'(win.hmin), 0);
    check("abort.hmax", 32'(win.hmax), 0);
    check("abort.vmin", 32'(win.vmin), 0);
    check("abort.vmax", 32'(win.vmax), 0);
    check("abort.busy", 32'(win.busy), 0);
    check("abort.upd", 32'(win.upd), 0);
    @(negedge clk);
    check("abort.upd2", 32'(win.upd), 0);
    reset_n = 1'b1;
    t0 = cyc;
    sb.push_back(mk("after_rst", 0, 1919, 180, 899, 0, 28));
    @(negedge clk);
    wait_upd(t0, 100);

    apply("hd0", 3, 0, 1080, 640, 240, mk("hd0", 0, 4095, 0, 1079, 0, 3), 1'b1, t0);
    wait_upd(t0, 20);

    apply("m1_wide", 1, 1920, 1080, 2000, 240, mk("m1_wide", 0, 1919, 420, 659, 0, 4), 1'b1,
          t0);
    wait_upd(t0, 20);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ascal_win_ctrl.md
Name: ascal_win_ctrl

Overview:
Sequencer that computes the scaler output window (hmin/hmax/vmin/vmax) from the display size (hdisp/vdisp) and the source image size, according to a placement mode. It sits between the test-pattern/control logic and the ascal scaler config ports. It recomputes automatically whenever any input changes, using a multi-cycle iterative path instead of wide combinational multiply/divide. All four window outputs update atomically.

Parameters:
W, 12, coordinate width for all sizes and window bounds.
AUTO_REQ, 1, when 1, any change of the latched inputs starts a recompute.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  1  single-cycle recompute request
mode  in  2  0=1:1 centered, 1=integer scale, 2=aspect fit, 3=stretch
hdisp  in  W  display width
vdisp  in  W  display height
in_w  in  W  source width
in_h  in  W  source height
ps2_key  in  11  keyboard event; bit10 toggles per event; used only with the optional feature
hmin  out  W  window left
hmax  out  W  window right, inclusive
vmin  out  W  window top
vmax  out  W  window bottom, inclusive
upd  out  1  one-cycle pulse; outputs changed in this cycle
busy  out  1  high from LATCH through COMMIT
err  out  1  sticky until next commit: the last compute had in_w==0 or in_h==0

Behaviour:
- Reset: all outputs 0; state IDLE; latched inputs 0; pending cleared.
- Start conditions, evaluated in IDLE: req, or (AUTO_REQ and any of mode/hdisp/vdisp/in_w/in_h differs from its latched copy). A start that arrives outside IDLE sets pending. After COMMIT, pending returns the FSM to LATCH and clears.
- LATCH: capture all inputs, 1 cycle. If in_w==0 or in_h==0, force mode 3 and set err_next.
- Mode 3: w=hdisp, h=vdisp, go to CENTER.
- Mode 0: w=min(in_w,hdisp), h=min(in_h,vdisp), go to CENTER.
- Mode 1, ISCALE state: accumulators aw=in_w, ah=in_h, k=1. Each cycle, if aw+in_w<=hdisp and ah+in_h<=vdisp, add and increment k; else exit. Sums are W+1 bits to prevent wrap. Then w=min(aw,hdisp), h=min(ah,vdisp). Takes k cycles.
- Mode 2, DIV1: h=hdisp*in_h/in_w through the 2W-bit restoring divider (2W cycles). Quotient saturates to 2^W-1. CHK: if h<=vdisp then w=hdisp, else DIV2: w=vdisp*in_w/in_h, h=vdisp. All quotients truncate.
- CENTER: hmin=(hdisp-w)>>1, hmax=hmin+w-1, same for the vertical axis. 1 cycle.
- COMMIT: drive the outputs and err, pulse upd. 1 cycle.
- Latency from start cycle to upd:
  - modes 0 and 3: 3 cycles
  - mode 1: 3+k cycles
  - mode 2: 3+2W+1 cycles (+2W more if DIV2 runs)
- hdisp or vdisp == 0: w/h become 0. hmax=hmin-1 wraps to all-ones. This is the defined "no window" encoding.
- Reset asserted mid-compute: abort immediately, outputs return to 0, no upd.

Optional Feature:
Macro ASCAL_WIN_KEYB_EN.
- Defined: a bit10 toggle on ps2_key with make code (bit9=1) selects the mode override:
  - F1(0x05)=0, F2(0x06)=1, F3(0x04)=2, F4(0x0C)=3
  - F5(0x03) releases the override
  - Effective mode = override if active, else mode. A change in the effective mode triggers auto-start.
- Not defined: ps2_key is unused, no override register is built, and the effective mode is always mode.

Decomposition:
- Package ascal_win_pkg:
  - W default constant
  - mode_t enum {M_1TO1, M_INT, M_FIT, M_STRETCH}
  - state_t enum {IDLE, LATCH, ISCALE, DIV1, CHK, DIV2, CENTER, COMMIT}
  - PS/2 keycode constants
- One sub-module, ascal_win_div: sequential restoring divider, 2W-bit numerator by W-bit denominator.
  - Ports: start/done handshake; done pulses 2W cycles after start.
  - The denominator is guaranteed nonzero by the LATCH check.

Test Plan:
- hdisp=1920, vdisp=1080, in 320x240, mode 3 -> 0/1919/0/1079, upd 3 cycles after req.
- Same inputs, mode 0 -> hmin=800, hmax=1119, vmin=420, vmax=659.
- Same inputs, mode 1 -> k=4; 320/1599/60/1019; upd at cycle 7.
- Same inputs, mode 2 -> DIV1 gives 1440>1080, so DIV2 runs; 240/1679/0/1079; busy through both divides.
- in_w=0, mode 2 -> err=1, full window 0/1919/0/1079. A following valid compute clears err on its upd.
- While busy in mode 2, change in_w to 640 and pulse reset_n mid-run:
  - Without reset: a second upd follows the first.
  - With reset: outputs 0, no upd, then an auto-start after reset yields the correct window.
